// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial IP.
// Frame FSM states, parity modes, CONTROL layout, parity helper.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int CTRL_PAR   = 1;
  localparam int CTRL_STOP2 = 3;
  localparam int CTRL_SIZE  = 4;
  localparam int CTRL_MSB   = 5;

  // Parity over only the bits that go on the line (size+5 of them).
  function automatic logic parity_bit(
    input logic [7:0] data,
    input logic [1:0] size,
    input logic [1:0] mode
  );
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (2'd3 - size);
    x    = ^(data & mask);
    unique case (mode)
      PAR_NONE: parity_bit = 1'b0;
      PAR_EVEN: parity_bit = x;
      PAR_ODD:  parity_bit = ~x;
      PAR_MARK: parity_bit = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/serial_baud_timer.sv
// serial_baud_timer: 24.8 fixed-point phase accumulator.
// Pulses bit_done on the last clock of each bit period.
module serial_baud_timer #(
  parameter int BRD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 run,
  input  logic [BRD_WIDTH-1:0] brd,
  output logic                 bit_done
);

  localparam logic [BRD_WIDTH-1:0] STEP = BRD_WIDTH'(256);

  logic [BRD_WIDTH-1:0] acc;
  logic [BRD_WIDTH-1:0] target;
  logic [BRD_WIDTH-1:0] step;
  logic [BRD_WIDTH-1:0] edge_at;

  // acc holds whole clocks; target keeps its fraction so the
  // rounding error never builds up across bits.
  assign edge_at  = {target[BRD_WIDTH-1:8], 8'h00};
  assign bit_done = run && (acc >= edge_at);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      target <= '0;
      step   <= '0;
    end else if (load) begin
      acc    <= STEP;
      target <= brd;
      step   <= brd;
    end else if (run) begin
      acc <= acc + STEP;
      if (bit_done) begin
        target <= target + step;
      end
    end
  end

endmodule

// File: rtl/serial_tx_engine.sv
// serial_tx_engine: pops the TX FIFO and serialises each word
// as an async frame (start, 5-8 data, parity, 1-2 stop).
module serial_tx_engine
  import serial_pkg::*;
#(
  parameter int BRD_WIDTH  = 32,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            size,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  input  logic [BRD_WIDTH-1:0]  brd,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy
);

  tx_state_t state_q, state_d;

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic       par_q, par_d;

  logic [CTRL_MSB:CTRL_PAR] ctrl_q, ctrl_d;

  logic [1:0] size_s;
  logic [1:0] mode_s;
  logic       stop2_s;
  logic [2:0] last_bit;
  logic       start_ok;
  logic       frame_end;
  logic       pop;
  logic       bit_done;
  logic       unused_fifo_hi;

  assign size_s   = ctrl_q[CTRL_SIZE +: 2];
  assign mode_s   = ctrl_q[CTRL_PAR +: 2];
  assign stop2_s  = ctrl_q[CTRL_STOP2];
  assign last_bit = {1'b1, size_s};

  assign start_ok = enable && !fifo_empty
                 && (brd[BRD_WIDTH-1:8] != '0);

  assign frame_end = (state_q == STOP) && bit_done
                  && (!stop2_s || cnt_q[0]);

  // Popping on the final stop clock keeps frames back to back.
  assign pop = !reset && start_ok
            && ((state_q == IDLE) || frame_end);

  assign fifo_rd = pop;
  assign busy    = (state_q != IDLE);

  assign unused_fifo_hi = ^fifo_data[DATA_WIDTH-1:8];

  serial_baud_timer #(
    .BRD_WIDTH (BRD_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (pop),
    .run      (busy),
    .brd      (brd),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    ctrl_d  = ctrl_q;
    tx      = 1'b1;

    unique case (state_q)
      IDLE: begin
        tx = 1'b1;
      end
      START: begin
        tx = 1'b0;
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        tx = shreg_q[0];
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == last_bit) begin
            cnt_d   = '0;
            state_d = (mode_s == PAR_NONE)
                    ? STOP : PARITY;
          end
        end
      end
      PARITY: begin
        tx = par_q;
        if (bit_done) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (bit_done) begin
          cnt_d = cnt_q + 3'd1;
          if (frame_end) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      state_d = START;
      shreg_d = fifo_data[7:0];
      cnt_d   = '0;
      ctrl_d[CTRL_SIZE +: 2] = size;
      ctrl_d[CTRL_PAR +: 2]  = parity_mode;
      ctrl_d[CTRL_STOP2]     = stop2;
      par_d = parity_bit(fifo_data[7:0],
                         size, parity_mode);
    end
  end

endmodule

// File: tb/tb_serial_tx_engine.sv
// tb_serial_tx_engine: scoreboard bench for the UART transmit engine.
// Each pushed byte queues its expected per-clock line waveform.
`timescale 1ns/1ps
module tb_serial_tx_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  size = 2'b11;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop2 = 1'b0;
  logic [31:0] brd = 32'h0000_0A00;
  logic        fifo_empty = 1'b1;
  logic [8:0]  fifo_data = '0;
  logic        fifo_rd;
  logic        tx;
  logic        busy;

  logic [8:0] fifo_q[$];
  bit         exp_q[$];
  logic       obs_q[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int pops = 0;
  int rd_empty = 0;
  int busy_cyc = 0;
  int first_rd = -1;
  int first_busy = -1;

  serial_tx_engine dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .size        (size),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .brd         (brd),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic sync_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 9'h000 : fifo_q[0];
  endtask

  task automatic set_cfg(input logic [1:0] sz,
                         input logic [1:0] pm,
                         input logic s2,
                         input logic [31:0] b);
    size = sz;
    parity_mode = pm;
    stop2 = s2;
    brd = b;
  endtask

  // Expected line: bit k occupies clocks floor(k*brd/256) .. floor((k+1)*brd/256)-1.
  task automatic push_exp(input logic [7:0] d);
    bit bits[$];
    bit x;
    longint unsigned b, s, e;
    x = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(size) + 5; i++) begin
      bits.push_back(d[i]);
      x = x ^ d[i];
    end
    case (parity_mode)
      2'b01: bits.push_back(x);
      2'b10: bits.push_back(~x);
      2'b11: bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    b = 64'(brd);
    for (int k = 0; k < bits.size(); k++) begin
      s = (64'(k) * b) >> 8;
      e = (64'(k + 1) * b) >> 8;
      for (longint unsigned c = s; c < e; c++)
        exp_q.push_back(bits[k]);
    end
  endtask

  task automatic push_raw(input logic [7:0] d);
    fifo_q.push_back({1'($urandom), d});
    sync_fifo();
  endtask

  task automatic push_byte(input logic [7:0] d);
    push_exp(d);
    push_raw(d);
  endtask

  task automatic tick();
    logic rd_s;
    #1;
    rd_s = fifo_rd;
    if (rd_s) begin
      pops++;
      if (first_rd < 0) first_rd = cyc;
      if (fifo_empty) rd_empty++;
    end
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    sync_fifo();
    @(negedge clk);
    cyc++;
  endtask

  // Records the line while busy until the engine goes idle again.
  // chg_kind 1 scrambles config/brd, 2 drops enable, at cycle chg_at.
  task automatic run_frames(input int max_cyc, input int chg_at,
                            input int chg_kind, output bit tmo);
    bit started;
    started = 1'b0;
    tmo = 1'b1;
    obs_q.delete();
    pops = 0;
    rd_empty = 0;
    busy_cyc = 0;
    first_rd = -1;
    first_busy = -1;
    for (int n = 0; n < max_cyc; n++) begin
      if (n == chg_at && chg_kind == 1) set_cfg(2'b00, 2'b10, 1'b1, 32'h300);
      if (n == chg_at && chg_kind == 2) enable = 1'b0;
      tick();
      if (busy) begin
        if (!started) first_busy = cyc;
        started = 1'b1;
        obs_q.push_back(tx);
        busy_cyc++;
      end else if (started) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    push_raw(8'h11);
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
    checks++;
    if (fifo_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", fifo_rd);
    else passed++;
    fifo_q.delete();
    sync_fifo();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    bit tmo;
    int idx;
    set_cfg(2'b11, 2'b00, 1'b0, 32'h0000_0A00);
    exp_q.delete();
    push_byte(8'h55);
    run_frames(400, -1, 0, tmo);
    checks++;
    if (tmo) $display("FAIL 8n1_timeout: frame did not finish");
    else passed++;
    checks++;
    if (pops !== 1) $display("FAIL 8n1_pops: got %0d want 1", pops);
    else passed++;
    checks++;
    if (first_busy !== first_rd + 1)
      $display("FAIL 8n1_latency: busy at %0d want %0d", first_busy, first_rd + 1);
    else passed++;
    checks++;
    if (busy_cyc !== 100) $display("FAIL 8n1_busy_len: got %0d want 100", busy_cyc);
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL 8n1_wave_len: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && i < obs_q.size() && obs_q[i] !== exp_q[i]) idx = i;
    checks++;
    if (idx >= 0)
      $display("FAIL 8n1_wave: clk %0d got %b want %b", idx, obs_q[idx], exp_q[idx]);
    else passed++;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL 8n1_idle: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_frac_brd();
    bit tmo;
    int idx;
    set_cfg(2'b11, 2'b00, 1'b0, 32'h0000_0A80);
    push_byte(8'hA7);
    run_frames(400, 30, 1, tmo);
    checks++;
    if (tmo || busy_cyc !== 105)
      $display("FAIL frac_len: got %0d (timeout %b) want 105", busy_cyc, tmo);
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL frac_wave_len: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && i < obs_q.size() && obs_q[i] !== exp_q[i]) idx = i;
    checks++;
    if (idx >= 0)
      $display("FAIL frac_wave: clk %0d got %b want %b", idx, obs_q[idx], exp_q[idx]);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_7e2();
    bit tmo;
    int idx;
    set_cfg(2'b10, 2'b01, 1'b1, 32'h0000_0400);
    push_byte(8'h03);
    run_frames(400, -1, 0, tmo);
    checks++;
    if (tmo || busy_cyc !== 44)
      $display("FAIL 7e2_len: got %0d (timeout %b) want 44", busy_cyc, tmo);
    else passed++;
    checks++;
    if (obs_q.size() <= 33 || obs_q[33] !== 1'b0)
      $display("FAIL 7e2_parity: got %b want 0", obs_q.size() > 33 ? obs_q[33] : 1'bx);
    else passed++;
    idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && i < obs_q.size() && obs_q[i] !== exp_q[i]) idx = i;
    checks++;
    if (idx >= 0)
      $display("FAIL 7e2_wave: clk %0d got %b want %b", idx, obs_q[idx], exp_q[idx]);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_5o1();
    bit tmo;
    int idx;
    set_cfg(2'b00, 2'b10, 1'b0, 32'h0000_0400);
    push_byte(8'hFF);
    run_frames(400, -1, 0, tmo);
    checks++;
    if (tmo || busy_cyc !== 32)
      $display("FAIL 5o1_len: got %0d (timeout %b) want 32", busy_cyc, tmo);
    else passed++;
    checks++;
    if (obs_q.size() <= 25 || obs_q[25] !== 1'b0)
      $display("FAIL 5o1_parity: got %b want 0", obs_q.size() > 25 ? obs_q[25] : 1'bx);
    else passed++;
    idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && i < obs_q.size() && obs_q[i] !== exp_q[i]) idx = i;
    checks++;
    if (idx >= 0 || obs_q.size() != exp_q.size())
      $display("FAIL 5o1_wave: clk %0d len %0d want len %0d", idx, obs_q.size(), exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit tmo;
    int idx;
    set_cfg(2'b11, 2'b00, 1'b0, 32'h0000_0400);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    run_frames(600, -1, 0, tmo);
    checks++;
    if (pops !== 3) $display("FAIL b2b_pops: got %0d want 3", pops);
    else passed++;
    checks++;
    if (tmo || busy_cyc !== 120)
      $display("FAIL b2b_len: got %0d (timeout %b) want 120", busy_cyc, tmo);
    else passed++;
    idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && i < obs_q.size() && obs_q[i] !== exp_q[i]) idx = i;
    checks++;
    if (idx >= 0 || obs_q.size() != exp_q.size())
      $display("FAIL b2b_wave: clk %0d len %0d want len %0d", idx, obs_q.size(), exp_q.size());
    else passed++;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_q.size() != 0)
      $display("FAIL b2b_idle: tx=%b busy=%b left=%0d want 1 0 0", tx, busy, fifo_q.size());
    else passed++;
    checks++;
    if (rd_empty !== 0) $display("FAIL b2b_rd_empty: got %0d want 0", rd_empty);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_enable_drop();
    bit tmo;
    int idx;
    logic [7:0] b2;
    set_cfg(2'b11, 2'b00, 1'b0, 32'h0000_0400);
    b2 = 8'hC4;
    push_byte(8'h3B);
    push_raw(b2);
    run_frames(400, 10, 2, tmo);
    checks++;
    if (tmo || pops !== 1 || fifo_q.size() != 1)
      $display("FAIL endrop_pops: got %0d left %0d want 1 1", pops, fifo_q.size());
    else passed++;
    idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && i < obs_q.size() && obs_q[i] !== exp_q[i]) idx = i;
    checks++;
    if (idx >= 0 || obs_q.size() != exp_q.size())
      $display("FAIL endrop_wave: clk %0d len %0d want len %0d", idx, obs_q.size(), exp_q.size());
    else passed++;
    exp_q.delete();
    pops = 0;
    repeat (10) tick();
    checks++;
    if (pops !== 0 || busy !== 1'b0)
      $display("FAIL endrop_hold: pops=%0d busy=%b want 0 0", pops, busy);
    else passed++;
    push_exp(b2);
    enable = 1'b1;
    run_frames(400, -1, 0, tmo);
    idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && i < obs_q.size() && obs_q[i] !== exp_q[i]) idx = i;
    checks++;
    if (tmo || pops !== 1 || idx >= 0 || obs_q.size() != exp_q.size())
      $display("FAIL endrop_resume: pops=%0d clk %0d len %0d want 1 -1 %0d",
               pops, idx, obs_q.size(), exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_slow_brd();
    int hi_miss;
    set_cfg(2'b11, 2'b00, 1'b0, 32'h0000_00FF);
    push_raw(8'h42);
    pops = 0;
    hi_miss = 0;
    repeat (20) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) hi_miss++;
    end
    checks++;
    if (pops !== 0 || hi_miss !== 0)
      $display("FAIL slow_brd: pops=%0d active=%0d want 0 0", pops, hi_miss);
    else passed++;
    fifo_q.delete();
    sync_fifo();
  endtask

  task automatic test_mid_reset();
    int hi_miss;
    set_cfg(2'b11, 2'b00, 1'b0, 32'h0000_0A00);
    push_raw(8'h5A);
    repeat (25) tick();
    checks++;
    if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_async: tx=%b busy=%b want 1 0", tx, busy);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    pops = 0;
    hi_miss = 0;
    repeat (30) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) hi_miss++;
    end
    checks++;
    if (pops !== 0 || hi_miss !== 0)
      $display("FAIL rst_after: pops=%0d active=%0d want 0 0", pops, hi_miss);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_frac_brd();
    test_7e2();
    test_5o1();
    test_back_to_back();
    test_enable_drop();
    test_slow_brd();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
